// File: rtl/arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner ids, wait counter width.
package arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_done;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and memory model side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
        input  cpu_gnt, cpu_done, ext_gnt, ext_done, rdata,
        input  mem_addr, mem_wdata, mem_we
    );

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
        output cpu_gnt, cpu_done, ext_gnt, ext_done, rdata,
        output mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way picker: round-robin on a tie, or CPU-always-wins when
// ARB_FIXED_PRIO_EN is defined.
module rr_pick2
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        valid  = |req;
        winner = OWN_CPU;
        if (req == 2'b10) begin
            winner = OWN_EXT;
        end else if (req == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
            winner = OWN_CPU;
`else
            winner = ~last_owner;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU and the external loader with a fixed-latency
// IDLE/ACCESS/RESP sequence. ARB_FIXED_PRIO_EN switches tie-breaking to CPU priority.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mem_port_arbiter: WAIT_CYCLES must be within 1..15");
    end

    arb_state_t        state, state_nxt;
    logic              owner, owner_nxt;
    logic              last_owner, last_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              we_q, we_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic              mem_we_q, mem_we_nxt;
    logic              cpu_gnt_q, cpu_gnt_nxt;
    logic              ext_gnt_q, ext_gnt_nxt;
    logic              cpu_done_q, cpu_done_nxt;
    logic              ext_done_q, ext_done_nxt;
    logic              pick_valid;
    logic              pick_winner;

    rr_pick2 u_pick (
        .req        ({bus.ext_req, bus.cpu_req}),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Next state plus next values of every registered output
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        last_nxt   = last_owner;
        cnt_nxt    = cnt;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        we_nxt     = we_q;
        rdata_nxt  = rdata_q;
        mem_we_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = ACCESS;
                    owner_nxt = pick_winner;
                    cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                    if (pick_winner == OWN_EXT) begin
                        addr_nxt  = bus.ext_addr;
                        wdata_nxt = bus.ext_wdata;
                        we_nxt    = bus.ext_we;
                    end else begin
                        addr_nxt  = bus.cpu_addr;
                        wdata_nxt = bus.cpu_wdata;
                        we_nxt    = bus.cpu_we;
                    end
                    // Write strobe only during the first access cycle
                    mem_we_nxt = we_nxt;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    last_nxt  = owner;
                    if (!we_q) begin
                        rdata_nxt = bus.mem_rdata;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        cpu_gnt_nxt  = (state_nxt != IDLE) && (owner_nxt == OWN_CPU);
        ext_gnt_nxt  = (state_nxt != IDLE) && (owner_nxt == OWN_EXT);
        cpu_done_nxt = (state_nxt == RESP) && (owner_nxt == OWN_CPU);
        ext_done_nxt = (state_nxt == RESP) && (owner_nxt == OWN_EXT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_EXT;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            mem_we_q   <= 1'b0;
            cpu_gnt_q  <= 1'b0;
            ext_gnt_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            ext_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_nxt;
            cnt        <= cnt_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            we_q       <= we_nxt;
            rdata_q    <= rdata_nxt;
            mem_we_q   <= mem_we_nxt;
            cpu_gnt_q  <= cpu_gnt_nxt;
            ext_gnt_q  <= ext_gnt_nxt;
            cpu_done_q <= cpu_done_nxt;
            ext_done_q <= ext_done_nxt;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.ext_gnt   = ext_gnt_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.ext_done  = ext_done_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_CYCLES 1 and 3) share one stimulus.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned WA = 1;
    localparam int unsigned WB = 3;

    typedef struct packed {
        logic          cpu_gnt;
        logic          cpu_done;
        logic          ext_gnt;
        logic          ext_done;
        logic          mem_we;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic [DW-1:0] rdata;
    } out_t;

    typedef struct packed {
        logic          cpu_req;
        logic          cpu_we;
        logic [AW-1:0] cpu_addr;
        logic [DW-1:0] cpu_wdata;
        logic          ext_req;
        logic          ext_we;
        logic [AW-1:0] ext_addr;
        logic [DW-1:0] ext_wdata;
        logic [DW-1:0] mem_rdata;
    } in_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, ext_wdata = '0, mem_rdata = '0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

    assign if_a.cpu_req = cpu_req;     assign if_b.cpu_req = cpu_req;
    assign if_a.cpu_we = cpu_we;       assign if_b.cpu_we = cpu_we;
    assign if_a.cpu_addr = cpu_addr;   assign if_b.cpu_addr = cpu_addr;
    assign if_a.cpu_wdata = cpu_wdata; assign if_b.cpu_wdata = cpu_wdata;
    assign if_a.ext_req = ext_req;     assign if_b.ext_req = ext_req;
    assign if_a.ext_we = ext_we;       assign if_b.ext_we = ext_we;
    assign if_a.ext_addr = ext_addr;   assign if_b.ext_addr = ext_addr;
    assign if_a.ext_wdata = ext_wdata; assign if_b.ext_wdata = ext_wdata;
    assign if_a.mem_rdata = mem_rdata; assign if_b.mem_rdata = mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WB)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );

    out_t out_a, out_b;
    assign out_a = {if_a.cpu_gnt, if_a.cpu_done, if_a.ext_gnt, if_a.ext_done, if_a.mem_we,
                    if_a.mem_addr, if_a.mem_wdata, if_a.rdata};
    assign out_b = {if_b.cpu_gnt, if_b.cpu_done, if_b.ext_gnt, if_b.ext_done, if_b.mem_we,
                    if_b.mem_addr, if_b.mem_wdata, if_b.rdata};

    int checks = 0;
    int errors = 0;

    function automatic string fmt(input out_t o);
        return $sformatf("gnt(c,e)=%b%b done(c,e)=%b%b we=%b addr=%h wdata=%h rdata=%h",
                         o.cpu_gnt, o.ext_gnt, o.cpu_done, o.ext_done, o.mem_we,
                         o.mem_addr, o.mem_wdata, o.rdata);
    endfunction

    task automatic check_out(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %s | expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic in_t mk_in(input logic cr, input logic cw, input logic [31:0] ca,
                                  input logic [31:0] cd, input logic er, input logic ew,
                                  input logic [31:0] ea, input logic [31:0] ed,
                                  input logic [31:0] rd);
        in_t v;
        v = '{cpu_req: cr, cpu_we: cw, cpu_addr: ca, cpu_wdata: cd, ext_req: er, ext_we: ew,
              ext_addr: ea, ext_wdata: ed, mem_rdata: rd};
        return v;
    endfunction

    function automatic out_t mk_out(input logic cg, input logic cdn, input logic eg,
                                    input logic edn, input logic we, input logic [31:0] ma,
                                    input logic [31:0] mw, input logic [31:0] rd);
        out_t o;
        o = '{cpu_gnt: cg, cpu_done: cdn, ext_gnt: eg, ext_done: edn, mem_we: we,
              mem_addr: ma, mem_wdata: mw, rdata: rd};
        return o;
    endfunction

    task automatic apply_in(input in_t v);
        cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
        ext_req = v.ext_req; ext_we = v.ext_we; ext_addr = v.ext_addr; ext_wdata = v.ext_wdata;
        mem_rdata = v.mem_rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply_in('0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Transaction-level reference: each grant at edge g defines ACCESS g..g+W-1, RESP g+W
    int   ecnt;
    bit   m_busy[2];
    bit   m_own[2];
    bit   m_last[2];
    bit   m_we[2];
    int   m_g[2];
    logic [31:0] m_addr[2], m_wdata[2], m_rdata[2];

    function automatic int unsigned wait_of(input int i);
        return (i == 0) ? WA : WB;
    endfunction

    function automatic bit pick_ext(input bit cr, input bit er, input bit last);
        if (cr && er) begin
`ifdef ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return !last;
`endif
        end
        return er;
    endfunction

    task automatic model_reset(input int i);
        m_busy[i] = 0; m_own[i] = 0; m_last[i] = 1; m_we[i] = 0; m_g[i] = 0;
        m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i] = '0;
    endtask

    task automatic model_edge(input int i);
        int w;
        w = int'(wait_of(i));
        if (reset) begin
            model_reset(i);
        end else if (m_busy[i]) begin
            if (ecnt == m_g[i] + w) begin
                if (!m_we[i]) m_rdata[i] = mem_rdata;
                m_last[i] = m_own[i];
            end else if (ecnt == m_g[i] + w + 1) begin
                m_busy[i] = 0;
            end
        end else if (cpu_req || ext_req) begin
            m_own[i]  = pick_ext(cpu_req, ext_req, m_last[i]);
            m_busy[i] = 1;
            m_g[i]    = ecnt;
            m_addr[i] = m_own[i] ? ext_addr : cpu_addr;
            m_wdata[i] = m_own[i] ? ext_wdata : cpu_wdata;
            m_we[i]   = m_own[i] ? ext_we : cpu_we;
        end
    endtask

    function automatic out_t model_out(input int i);
        out_t o;
        int   w;
        bit   act, resp;
        w    = int'(wait_of(i));
        act  = m_busy[i] && (ecnt <= m_g[i] + w);
        resp = m_busy[i] && (ecnt == m_g[i] + w);
        o = mk_out(act && !m_own[i], resp && !m_own[i], act && m_own[i], resp && m_own[i],
                   m_busy[i] && (ecnt == m_g[i]) && m_we[i], m_addr[i], m_wdata[i], m_rdata[i]);
        return o;
    endfunction

    vec_t tbl[12];
    int   nd;
    bit   exp_ext;

    initial begin
        // Cycle-by-cycle vectors for the WAIT_CYCLES=1 instance
        tbl[0]  = '{mk_in(1,0,32'h10,0, 0,0,0,0, 32'hDEADBEEF),
                    mk_out(1,0,0,0,0, 32'h10,0,0)};
        tbl[1]  = '{mk_in(1,0,32'h20,0, 0,0,0,0, 32'hDEADBEEF),
                    mk_out(1,1,0,0,0, 32'h10,0,32'hDEADBEEF)};
        tbl[2]  = '{mk_in(0,0,0,0, 0,0,0,0, 0),
                    mk_out(0,0,0,0,0, 32'h10,0,32'hDEADBEEF)};
        tbl[3]  = '{mk_in(0,0,0,0, 1,1,32'h40,32'h1234, 32'h11111111),
                    mk_out(0,0,1,0,1, 32'h40,32'h1234,32'hDEADBEEF)};
        tbl[4]  = '{mk_in(0,0,0,0, 1,0,32'h99,0, 32'h22222222),
                    mk_out(0,0,1,1,0, 32'h40,32'h1234,32'hDEADBEEF)};
        tbl[5]  = '{mk_in(0,0,0,0, 0,0,0,0, 0),
                    mk_out(0,0,0,0,0, 32'h40,32'h1234,32'hDEADBEEF)};
        tbl[6]  = '{mk_in(1,1,32'h30,32'hA5A5, 0,0,0,0, 32'h33),
                    mk_out(1,0,0,0,1, 32'h30,32'hA5A5,32'hDEADBEEF)};
        tbl[7]  = '{mk_in(0,0,0,0, 0,0,0,0, 0),
                    mk_out(1,1,0,0,0, 32'h30,32'hA5A5,32'hDEADBEEF)};
        tbl[8]  = '{mk_in(0,0,0,0, 1,0,32'h50,0, 32'h44),
                    mk_out(0,0,0,0,0, 32'h30,32'hA5A5,32'hDEADBEEF)};
        tbl[9]  = '{mk_in(0,0,0,0, 1,0,32'h50,0, 32'h5555),
                    mk_out(0,0,1,0,0, 32'h50,0,32'hDEADBEEF)};
        tbl[10] = '{mk_in(0,0,0,0, 1,0,32'h50,0, 32'h6666),
                    mk_out(0,0,1,1,0, 32'h50,0,32'h6666)};
        tbl[11] = '{mk_in(0,0,0,0, 0,0,0,0, 0),
                    mk_out(0,0,0,0,0, 32'h50,0,32'h6666)};

        do_reset();
        check_out("reset_a", out_a, '0);
        check_out("reset_b", out_b, '0);

        foreach (tbl[i]) begin
            apply_in(tbl[i].in);
            step();
            check_out($sformatf("table[%0d]", i), out_a, tbl[i].exp);
        end

        // External write, WAIT_CYCLES=3: one-cycle strobe, done after three access cycles
        do_reset();
        apply_in(mk_in(0,0,0,0, 1,1,32'h40,32'h1234, 32'hBAD0BAD0));
        for (int k = 1; k <= 6; k++) begin
            step();
            check_out($sformatf("ext_write[%0d]", k), out_b,
                      mk_out(0,0, k <= 4, k == 4, k == 1, 32'h40, 32'h1234, 0));
            if (k == 4) ext_req = 1'b0;
        end

        // Reset pulse during the first access cycle of a CPU write
        do_reset();
        apply_in(mk_in(1,1,32'h70,32'h77, 0,0,0,0, 32'h12345678));
        step();
        check_out("rst_mid_pre", out_b, mk_out(1,0,0,0,1, 32'h70,32'h77,0));
        #2;
        reset = 1'b1;
        #1;
        check_out("rst_mid_now", out_b, '0);
        ext_req = 1'b1;
        ext_addr = 32'h80;
        for (int k = 0; k < 2; k++) begin
            step();
            check_out($sformatf("rst_mid_held[%0d]", k), out_b, '0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_out($sformatf("rst_after[%0d]", k), out_b,
                      mk_out(k <= 4, k == 4, 0,0, k == 1, 32'h70, 32'h77, 0));
            if (k == 4) cpu_req = 1'b0;
        end
        ext_req = 1'b0;

        // Both requests held: grant order by done pulses
        do_reset();
        apply_in(mk_in(1,0,32'h100,0, 1,0,32'h200,0, 32'hCAFE0000));
        nd = 0;
        for (int c = 0; c < 40 && nd < 4; c++) begin
            step();
            if (out_a.cpu_done || out_a.ext_done) begin
`ifdef ARB_FIXED_PRIO_EN
                exp_ext = 1'b0;
`else
                exp_ext = (nd % 2) == 1;
`endif
                check_val($sformatf("tie_order[%0d]", nd),
                          {30'd0, out_a.cpu_done, out_a.ext_done},
                          exp_ext ? 32'd1 : 32'd2);
                nd++;
            end
        end
        check_val("tie_count", nd, 4);

        // Randomized traffic against the transaction-level model, both instances
        do_reset();
        model_reset(0);
        model_reset(1);
        ecnt = 0;
        for (int n = 0; n < 3000; n++) begin
            step();
            ecnt++;
            model_edge(0);
            model_edge(1);
            check_out($sformatf("rand_a[%0d]", n), out_a, model_out(0));
            check_out($sformatf("rand_b[%0d]", n), out_b, model_out(1));
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            ext_req   = ($urandom_range(0, 2) != 0);
            ext_we    = $urandom_range(0, 1) == 1;
            ext_addr  = $urandom;
            ext_wdata = $urandom;
            mem_rdata = $urandom;
            reset     = ($urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single shared instruction/data memory port between two requesters.
- Requester 0 is the multicycle CPU, covering fetch and load/store traffic. Requester 1 is the external loader/debug master, which writes program images and peeks and pokes data.
- Sequences each access with a fixed-latency FSM and returns read data with a one-cycle done pulse.
- The CPU control FSM holds its state while waiting for cpu_done.

Parameters:
- ADDR_W, 32, address width of requesters and memory
- DATA_W, 32, data width
- WAIT_CYCLES, 1, memory access cycles per transaction; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU requests an access; held until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU owns the port (high from ACCESS entry through RESP)
- cpu_done  out  1  one-cycle pulse; transaction complete
- ext_req  in  1  external master request; held until ext_done
- ext_we  in  1  1 = write
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_gnt  out  1  external master owns the port
- ext_done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  registered read data; valid while the corresponding done is high, held afterwards
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data, valid by the last ACCESS cycle

Behaviour:
- Reset values:
  - state = IDLE, owner = 0, last_owner = 1, so the CPU wins the first tie.
  - All outputs 0: gnt, done, mem_we, mem_addr, mem_wdata, rdata.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select the owner: a single requester wins; if both request, round-robin picks the requester that is not last_owner.
  - Latch addr, wdata and we of the winner into registers, set owner, load the wait counter with WAIT_CYCLES-1, and go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers; the owner's gnt is high.
  - mem_we is high only in the first ACCESS cycle, and only if the latched we = 1.
  - The counter decrements each cycle. When it is 0, capture mem_rdata into rdata (reads only; writes leave rdata unchanged), set last_owner = owner, and go to RESP.
- RESP:
  - The owner's done is high for exactly one cycle; gnt stays high.
  - Always go to IDLE, so there is at least one IDLE cycle between transactions.
- Latency: request seen in IDLE at cycle t → ACCESS from t+1 to t+WAIT_CYCLES → done at t+WAIT_CYCLES+1.
- Request inputs are sampled only in IDLE. Changes to addr, wdata or we after the grant are ignored.
- A requester dropping req mid-transaction does not abort: the transaction completes and done still pulses.
- The non-owner's gnt and done stay 0 throughout.
- Both requests held continuously: grants alternate CPU, EXT, CPU, ...
- Reset asserted mid-transaction: immediate return to reset values, including mem_we. No done is issued and the transaction is lost.
- Arithmetic: the counter is 4 bits wide and never wraps below 0. WAIT_CYCLES outside 1..15 is a configuration error checked by an elaboration-time assertion.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN
- Defined: on a tie the CPU always wins and last_owner is ignored. The external master is served only when cpu_req is low in IDLE, so starvation of the external master is permitted.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding constants: IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10
  - owner constants: OWN_CPU = 1'b0, OWN_EXT = 1'b1
  - wait counter width constant: 4
- One sub-module is natural: rr_pick2. It is a combinational 2-way picker with inputs req[1:0] and last_owner, and outputs valid and winner; the fixed-priority variant lives inside it under ARB_FIXED_PRIO_EN.
- The FSM, latches and counter stay in mem_port_arbiter.

Test Plan:
- Single CPU read, WAIT_CYCLES=1:
  - Stimulus: cpu_req=1, cpu_addr=0x10, mem_rdata=0xDEADBEEF at cycle t.
  - Response: cpu_gnt=1 at t+1; cpu_done=1 only at t+2 with rdata=0xDEADBEEF; mem_we=0 throughout.
- External write, WAIT_CYCLES=3:
  - Stimulus: ext_we=1, ext_addr=0x40, ext_wdata=0x0000_1234.
  - Response: mem_we high for exactly one cycle at t+1 with those values; ext_done at t+4; rdata unchanged.
- Simultaneous requests held for 4 transactions:
  - Response: grant order CPU, EXT, CPU, EXT.
  - With ARB_FIXED_PRIO_EN defined: CPU, CPU, CPU, CPU, and ext_done never pulses.
- CPU changes cpu_addr 0x10→0x20 during ACCESS:
  - Response: mem_addr stays 0x10 for the whole transaction.
- Reset pulse during ACCESS of a write with WAIT_CYCLES=3:
  - Response: mem_we, gnt and done go to 0 immediately, with no done.
  - A new cpu_req after reset release is served normally, with the CPU granted first.
- cpu_req dropped on the cycle after grant:
  - Response: cpu_done still pulses at t+WAIT_CYCLES+1, and the FSM returns to IDLE.
